// File: rtl/bus_pkg.sv
// Shared owner encodings, bus width defaults and burst counter sizing for the memory arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 8;
  localparam int BURST_MAX_DEF = 16;

  // Wide enough to hold the value BURST_MAX itself.
  function automatic int burst_cnt_w(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

  localparam int BURST_CNT_W = burst_cnt_w(BURST_MAX_DEF);

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way pick: sole requester wins; on a conflict either requester 0
// (fixed priority) or the requester that was not served last (round-robin).
module rr_pick2
  import bus_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic   req0,
  input  logic   req1,
  input  owner_t last_served,
  output owner_t pick
);

  // Pick the winner from the current request pair.
  always_comb begin
    pick = OWN_NONE;
    case ({req1, req0})
      2'b01: pick = OWN_P0;
      2'b10: pick = OWN_P1;
      2'b11: begin
        if (FIXED_PRIO != 0) begin
          pick = OWN_P0;
        end else if (last_served == OWN_P0) begin
          pick = OWN_P1;
        end else begin
          pick = OWN_P0;
        end
      end
      default: pick = OWN_NONE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared memory port, with registered grants/acks and lock bursts.
// Optional burst limit compiled in with `define ARB_BURST_LIMIT_EN.
module mem_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W     = bus_pkg::ADDR_W_DEF,
  parameter int DATA_W     = bus_pkg::DATA_W_DEF,
  parameter int FIXED_PRIO = 0,
  parameter int BURST_MAX  = bus_pkg::BURST_MAX_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              grant0,
  output logic              grant1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_t owner_r;
  owner_t last_served_r;
  owner_t eff_last_s;
  owner_t pick_s;
  owner_t next_owner_s;
  logic   acc0_s;
  logic   acc1_s;
  logic   locked_acc_s;
  logic   burst_hit_s;
  logic   keep0_s;
  logic   keep1_s;

  assign acc0_s       = grant0 & req0;
  assign acc1_s       = grant1 & req1;
  assign locked_acc_s = (acc0_s & lock0) | (acc1_s & lock1);
  assign rdata        = mem_rdata;

  // Drive the memory bus from whichever requester is accessing this cycle.
  always_comb begin
    mem_addr  = {ADDR_W{1'b0}};
    mem_we    = 1'b0;
    mem_wdata = {DATA_W{1'b0}};
    if (acc0_s) begin
      mem_addr  = addr0;
      mem_we    = we0;
      mem_wdata = wdata0;
    end else if (acc1_s) begin
      mem_addr  = addr1;
      mem_we    = we1;
      mem_wdata = wdata1;
    end else begin
      mem_addr  = {ADDR_W{1'b0}};
      mem_we    = 1'b0;
      mem_wdata = {DATA_W{1'b0}};
    end
  end

  // The access at this edge already counts as served for the next decision.
  always_comb begin
    eff_last_s = last_served_r;
    if (acc0_s) begin
      eff_last_s = OWN_P0;
    end else if (acc1_s) begin
      eff_last_s = OWN_P1;
    end else begin
      eff_last_s = last_served_r;
    end
  end

  rr_pick2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_served(eff_last_s),
    .pick       (pick_s)
  );

`ifdef ARB_BURST_LIMIT_EN
  localparam int CNT_W = burst_cnt_w(BURST_MAX);

  logic [CNT_W-1:0] burst_cnt_r;
  logic [CNT_W:0]   cnt_plus_s;

  // Includes the locked access happening at this edge, so exactly BURST_MAX are granted.
  assign cnt_plus_s  = {1'b0, burst_cnt_r} + {{CNT_W{1'b0}}, locked_acc_s};
  assign burst_hit_s = (cnt_plus_s >= (CNT_W + 1)'(BURST_MAX));

  // Consecutive locked-access counter; saturates when nobody is waiting to take over.
  always_ff @(posedge clock) begin
    if (reset) begin
      burst_cnt_r <= {CNT_W{1'b0}};
    end else if (next_owner_s != owner_r) begin
      burst_cnt_r <= {CNT_W{1'b0}};
    end else if (locked_acc_s) begin
      burst_cnt_r <= cnt_plus_s[CNT_W] ? burst_cnt_r : cnt_plus_s[CNT_W-1:0];
    end else if (acc0_s | acc1_s) begin
      burst_cnt_r <= {CNT_W{1'b0}};
    end else begin
      burst_cnt_r <= burst_cnt_r;
    end
  end
`else
  logic [31:0] burst_max_unused;

  assign burst_max_unused = 32'(BURST_MAX);
  assign burst_hit_s      = 1'b0;
`endif

  assign keep0_s = (owner_r == OWN_P0) & req0 & lock0 & ~(burst_hit_s & req1);
  assign keep1_s = (owner_r == OWN_P1) & req1 & lock1 & ~(burst_hit_s & req0);

  // Next owner: a held lock wins, otherwise the fair/priority pick.
  always_comb begin
    next_owner_s = pick_s;
    if (keep0_s) begin
      next_owner_s = OWN_P0;
    end else if (keep1_s) begin
      next_owner_s = OWN_P1;
    end else begin
      next_owner_s = pick_s;
    end
  end

  // Owner, last-served, grant and ack registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_r       <= OWN_NONE;
      last_served_r <= OWN_P1;
      grant0        <= 1'b0;
      grant1        <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
    end else begin
      owner_r       <= next_owner_s;
      last_served_r <= eff_last_s;
      grant0        <= (next_owner_s == OWN_P0);
      grant1        <= (next_owner_s == OWN_P1);
      ack0          <= acc0_s;
      ack1          <= acc1_s;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected acks are queued as accesses are granted
// and compared when the DUT acknowledges them.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int BM = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1, lock0, lock1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          grant0, grant1, ack0, ack1, mem_we;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic          fp_grant0, fp_grant1;
  logic          fp_unused_ack0, fp_unused_ack1, fp_unused_we;
  logic [DW-1:0] fp_unused_rdata, fp_unused_wdata;
  logic [AW-1:0] fp_unused_addr;

  logic [DW-1:0] mem [0:65535];

  typedef struct {
    int         port;
    bit         rd;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0), .BURST_MAX(BM)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .grant0(grant0), .grant1(grant1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1), .BURST_MAX(BM)) dut_fp (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .grant0(fp_grant0), .grant1(fp_grant1), .ack0(fp_unused_ack0), .ack1(fp_unused_ack1),
    .rdata(fp_unused_rdata), .mem_addr(fp_unused_addr), .mem_we(fp_unused_we),
    .mem_wdata(fp_unused_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: read data appears one cycle after the address.
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  task automatic push(input int port, input bit rd, input logic [7:0] d);
    exp_t e;
    e.port = port;
    e.rd   = rd;
    e.data = d;
    sb.push_back(e);
  endtask

  // Ack monitor: every ack must match the oldest queued access.
  always @(negedge clock) begin
    if (ack0 || ack1) begin
      if (sb.size() == 0) begin
        check("ack_unexpected", {30'd0, ack1, ack0}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_port", {30'd0, ack1, ack0}, (mon_e.port == 0) ? 32'd1 : 32'd2);
        if (mon_e.rd) check("rdata", {24'd0, rdata}, {24'd0, mon_e.data});
      end
    end
  end

  // Single access on a free bus: grant after one cycle, ack one cycle after the access.
  task automatic do_access(input int port, input bit wr, input logic [15:0] a,
                           input logic [7:0] wd, input logic [7:0] rd_exp, input string tag);
    int wait_n;
    bit got;
    if (port == 0) begin
      req0 = 1'b1; we0 = wr; addr0 = a; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = wr; addr1 = a; wdata1 = wd;
    end
    wait_n = 0;
    got    = 1'b0;
    while (!got && wait_n < 20) begin
      step();
      wait_n++;
      got = (port == 0) ? grant0 : grant1;
    end
    check({tag, "_latency"}, 32'(wait_n), 32'd1);
    if (got) begin
      check({tag, "_other_grant"}, {31'd0, (port == 0) ? grant1 : grant0}, 32'd0);
      check({tag, "_mem_addr"}, {16'd0, mem_addr}, {16'd0, a});
      check({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, wr});
      if (wr) check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, {24'd0, wd});
      push(port, !wr, rd_exp);
      step();
      check({tag, "_ack"}, {31'd0, (port == 0) ? ack0 : ack1}, 32'd1);
    end
    req0 = (port == 0) ? 1'b0 : req0;
    req1 = (port == 1) ? 1'b0 : req1;
    #1;
    check({tag, "_we_once"}, {31'd0, mem_we}, 32'd0);
    step();
    check({tag, "_grant_drop"}, {30'd0, grant1, grant0}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  done;
    for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
    mem[16'h0100] = 8'hA5;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    we0 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    step(); step();
    check("rst_grants", {30'd0, grant1, grant0}, 32'd0);
    check("rst_acks", {30'd0, ack1, ack0}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    reset = 1'b0;
    step();

    do_access(0, 1'b0, 16'h0100, 8'h00, 8'hA5, "rd0");
    do_access(1, 1'b1, 16'h5a00, 8'h48, 8'h00, "wr1");
    do_access(0, 1'b0, 16'h5a00, 8'h00, 8'h48, "rb0");

    // Continuous contention: round-robin alternates, fixed priority keeps P0.
    reset = 1'b1; step(); reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0200;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0300;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_grant0", {31'd0, grant0}, 32'((k % 2) == 0));
      check("rr_grant1", {31'd0, grant1}, 32'((k % 2) == 1));
      check("fp_grant0", {31'd0, fp_grant0}, 32'd1);
      check("fp_grant1", {31'd0, fp_grant1}, 32'd0);
      if (k > 0) check("rr_ack", {31'd0, ((k % 2) == 1) ? ack0 : ack1}, 32'd1);
      push(k % 2, 1'b1, init_val(((k % 2) == 0) ? 16'h0200 : 16'h0300));
    end
    step();
    req0 = 1'b0; req1 = 1'b0;
    step(); step();

    // Locked P1 burst while P0 waits.
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 16'h0400;
    step();
    check("burst_first_grant1", {31'd0, grant1}, 32'd1);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0500;
`ifdef ARB_BURST_LIMIT_EN
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      if (grant1) begin
        push(1, 1'b1, init_val(16'h0400));
        n++;
        step();
      end else begin
        done = 1'b1;
      end
    end
    check("burst_len", 32'(n), 32'(BM));
    check("burst_handover_grant0", {31'd0, grant0}, 32'd1);
    if (grant0) push(0, 1'b1, init_val(16'h0500));
    req1 = 1'b0; lock1 = 1'b0;
    step();
`else
    for (int i = 0; i < 8; i++) begin
      check("burst_hold_grant1", {31'd0, grant1}, 32'd1);
      push(1, 1'b1, init_val(16'h0400));
      step();
    end
    check("burst_hold_last", {31'd0, grant1}, 32'd1);
    push(1, 1'b1, init_val(16'h0400));
    lock1 = 1'b0;
    step();
    check("burst_release_grant0", {31'd0, grant0}, 32'd1);
    req1 = 1'b0;
    if (grant0) push(0, 1'b1, init_val(16'h0500));
    step();
`endif
    req0 = 1'b0;
    step(); step();

    // Reset during a P0 read access suppresses its ack.
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0100;
    step();
    check("rstmid_pre_grant0", {31'd0, grant0}, 32'd1);
    reset = 1'b1;
    step();
    check("rstmid_ack0", {31'd0, ack0}, 32'd0);
    check("rstmid_grant0", {31'd0, grant0}, 32'd0);
    check("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
    req0 = 1'b0;
    reset = 1'b0;
    step(); step();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
